// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, optional write-to-read
// bypass, an optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 32,
  parameter int unsigned       NUM_RD    = 2,
  parameter bit                BYPASS    = 1'b1,
  parameter bit                ZERO_REG  = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int unsigned      AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we0_i,
  input  logic [AW-1:0]            waddr0_i,
  input  logic [DATA_W-1:0]        wdata0_i,
  input  logic                     we1_i,
  input  logic [AW-1:0]            waddr1_i,
  input  logic [DATA_W-1:0]        wdata1_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic                     iss_valid_i,
  input  logic [AW-1:0]            iss_addr_i,
  output logic [DEPTH-1:0]         busy_vec_o
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wv0, wv1, issValid;

  // An address is usable only if it lies inside the array and is not the zero register.
  function automatic logic addrValid(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  assign wv0      = we0_i && addrValid(waddr0_i);
  assign wv1      = we1_i && addrValid(waddr1_i);
  assign issValid = iss_valid_i && addrValid(iss_addr_i);

  // Port 1 is applied after port 0 so it wins a same-address collision; the issue
  // set comes last so a new producer supersedes the retiring one.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wv0) begin
      regs_d[waddr0_i] = wdata0_i;
      busy_d[waddr0_i] = 1'b0;
    end
    if (wv1) begin
      regs_d[waddr1_i] = wdata1_i;
      busy_d[waddr1_i] = 1'b0;
    end
    if (issValid) begin
      busy_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          valid;
    logic          hit0;
    logic          hit1;

    assign addr  = raddr_i[k*AW +: AW];
    assign valid = addrValid(addr);
    assign hit1  = BYPASS && wv1 && (waddr1_i == addr);
    assign hit0  = BYPASS && wv0 && (waddr0_i == addr);

    assign rdata_o[k*DATA_W +: DATA_W] = hit1  ? wdata1_i :
                                         hit0  ? wdata0_i :
                                         valid ? regs_q[addr] : '0;

    // A forwarded write retires the pending producer, so the consumer need not stall.
    assign rbusy_o[k] = valid && busy_q[addr] && !hit1 && !hit0;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the next datapath generation. Provides NUM_RD combinational read ports and two write ports with deterministic same-address priority. Optional write-to-read bypass and a hardwired zero register are selectable by parameter. A per-register busy scoreboard is set at issue and cleared at writeback, so the hazard unit can stall on pending producers.

Parameters:
DATA_W, 32, width of each register in bits.
DEPTH, 32, number of registers; need not be a power of two.
NUM_RD, 2, number of read ports; valid range 1..4.
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored contents only.
ZERO_REG, 1, 1 = register 0 always reads 0, is never written and is never busy.
RESET_VAL, 0, value loaded into every register on reset (DATA_W bits).
AW (localparam), clog2(DEPTH) with a minimum of 1, address width.

Ports:
clk  in  1  clock; all state updates on the posedge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
we0  in  1  write enable for port 0.
waddr0  in  AW  write address for port 0.
wdata0  in  DATA_W  write data for port 0.
we1  in  1  write enable for port 1; port 1 has priority over port 0.
waddr1  in  AW  write address for port 1.
wdata1  in  DATA_W  write data for port 1.
raddr  in  NUM_RD*AW  packed read addresses; port k occupies slice k.
rdata  out  NUM_RD*DW  packed read data; DW = DATA_W.
rbusy  out  NUM_RD  busy flag for each read address.
iss_valid  in  1  issue strobe: marks register iss_addr as pending.
iss_addr  in  AW  destination register being issued.
busy_vec  out  DEPTH  full scoreboard, one bit per register.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers take RESET_VAL immediately; register 0 takes 0 when ZERO_REG=1.
  - All busy bits clear to 0.
  - Writes and issues are ignored while rst=0.
  - After release, state updates resume at the first posedge.
- Outputs during reset: rdata returns RESET_VAL (or 0 for register 0 when ZERO_REG=1), subject to bypass; rbusy=0; busy_vec=0.
- Write at posedge:
  - When weX=1 and waddrX is valid, reg[waddrX] <= wdataX.
  - Valid address: waddrX < DEPTH, and also waddrX != 0 when ZERO_REG=1.
  - If we0 and we1 both target the same address, port 1 data is stored.
  - Writes to different addresses both commit in the same cycle.
- Read: combinational, zero latency.
  - Returns 0 for addr >= DEPTH.
  - Returns 0 for addr 0 when ZERO_REG=1.
- Bypass (BYPASS=1): read port k returns, in priority order:
  1. wdata1, if we1=1 and waddr1==raddr[k] and the address is valid;
  2. else wdata0 under the same condition for port 0;
  3. else the stored value.
- With BYPASS=0, a written value is visible on reads only from the cycle after the write.
- Scoreboard, updated at posedge:
  - Any valid write to address A clears busy[A].
  - iss_valid=1 with a valid iss_addr sets busy[iss_addr].
  - Set and clear on the same address in the same cycle: set wins, because the new producer supersedes the retiring one.
  - Invalid iss_addr is ignored.
  - Issue to an already-busy register keeps it busy.
- rbusy[k]:
  - Normally equals busy[raddr[k]].
  - With BYPASS=1, it is forced to 0 when a valid write to raddr[k] is presented in the same cycle.
  - It is 0 for invalid addresses.
- busy_vec is the registered scoreboard state with no bypass; bit 0 is constant 0 when ZERO_REG=1.
- Simultaneous write and read of a non-bypassed address return the old value.
- No internal FSM beyond the register array and the DEPTH busy flops; the design is fully synchronous apart from the reset.

Test Plan:
1. Reset and zero register: hold rst=0 with we0=1, waddr0=3, wdata0=32'hDEAD. Expect all reads 0 and busy_vec=0. Release rst. Write 32'h1234 to register 0, then read register 0. Expect rdata=0 and no busy bit set.
2. Write priority: in one cycle set we0=1, waddr0=5, wdata0=32'hAAAA and we1=1, waddr1=5, wdata1=32'hBBBB. Next cycle, reading register 5 returns 32'hBBBB. Repeat with waddr1=6: register 5 = 32'hAAAA and register 6 = 32'hBBBB.
3. Bypass: set BYPASS=1, raddr port0=7, we1=1, waddr1=7, wdata1=32'hCAFE. rdata port0 = 32'hCAFE in the same cycle. With BYPASS=0, the same stimulus returns the old value until after the posedge.
4. Scoreboard: issue register 9, then one cycle later busy_vec[9]=1 and rbusy=1 for raddr=9. Write register 9: rbusy drops in the same cycle (BYPASS=1) and busy_vec[9]=0 after the edge. Issue register 9 and write register 9 in the same cycle: busy_vec[9] remains 1.
5. Non-power-of-two: DEPTH=24, NUM_RD=3. A write to address 30 is ignored; a read of address 30 returns 0 with rbusy=0. All three read ports return independent values for registers 1, 12 and 23.
6. Reset mid-operation: with registers written and busy bits set, assert rst=0 between clock edges. Expect rdata=RESET_VAL and busy_vec=0 immediately, without waiting for a clock edge.
